// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl
//   Sits between the data cache and a 32-bit word RAM. Takes one 128-bit line
//   request (fill, write-back, write-back followed by fill, or masked uncached
//   store) and breaks it into word beats on the RAM port.
//
//   Ports
//     CLK, RST      clock; synchronous active-high reset
//     req_read      line fill request (level, held until req_done)
//     req_write     write request (level, held until req_done)
//     req_addr      fill address, or store address when req_read=0
//     req_wb_addr   write-back address when both req_read and req_write are set
//     req_wdata     line to write, word n = [32n+31:32n]
//     req_mask      byte enables, nibble n belongs to word n
//     req_rdata     filled line, valid from req_done until the next accepted read
//     req_busy      high while a request is in progress
//     req_done      one-cycle completion pulse
//     ram_en        beat request
//     ram_we        byte write enables (0 on read beats)
//     ram_addr      word address {line, beat, 2'b00}
//     ram_wdata     write word
//     ram_rdata     read word, valid with ram_ready on a read beat
//     ram_ready     beat complete

module mem_line_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [ADDR_W-1:0]       req_wb_addr,
  input  logic [32*LINE_WORDS-1:0] req_wdata,
  input  logic [4*LINE_WORDS-1:0] req_mask,
  output logic [32*LINE_WORDS-1:0] req_rdata,
  output logic                    req_busy,
  output logic                    req_done,
  output logic                    ram_en,
  output logic [3:0]              ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata,
  input  logic                    ram_ready
);

  localparam int LINE_W = ADDR_W - 4;
  localparam int MASK_W = 4 * LINE_WORDS;
  localparam int LDAT_W = 32 * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t              state;
  logic [1:0]          beat;
  logic                rd_q;
  logic [LINE_W-1:0]   wr_line_q;
  logic [LINE_W-1:0]   rd_line_q;
  logic [LDAT_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   mask_q;

  // Byte offset within the line never matters: beats are whole words.
  logic unused_ok;
  assign unused_ok = ^{req_addr[3:0], req_wb_addr[3:0]};

  // Lowest beat at or above 'from' whose mask nibble is non-zero.
  // Returns {found, index}; write beats with an empty nibble cost no cycles.
  function automatic logic [2:0] find_beat(input logic [MASK_W-1:0] m,
                                           input logic [2:0]        from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && m[4*i +: 4] != 4'h0) begin
        r = {1'b1, i[1:0]};
      end
    end
    return r;
  endfunction

  logic [2:0]        fb_acc;
  logic [2:0]        fb_nxt;
  logic [LINE_W-1:0] wr_line_in;

  always_comb begin
    fb_acc     = find_beat(req_mask, 3'd0);
    fb_nxt     = find_beat(mask_q, {1'b0, beat} + 3'd1);
    wr_line_in = req_read ? req_wb_addr[ADDR_W-1:4] : req_addr[ADDR_W-1:4];
  end

  // All outputs are registered; each transition loads the next beat's
  // RAM signals so a phase change costs no idle cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      beat      <= 2'd0;
      req_busy  <= 1'b0;
      req_done  <= 1'b0;
      req_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_done <= 1'b0;
          if (req_read || req_write) begin
            req_busy  <= 1'b1;
            rd_q      <= req_read;
            wdata_q   <= req_wdata;
            mask_q    <= req_mask;
            wr_line_q <= wr_line_in;
            rd_line_q <= req_addr[ADDR_W-1:4];
            if (req_write && fb_acc[2]) begin
              state     <= WRITE;
              beat      <= fb_acc[1:0];
              ram_en    <= 1'b1;
              ram_we    <= req_mask[4*fb_acc[1:0] +: 4];
              ram_wdata <= req_wdata[32*fb_acc[1:0] +: 32];
              ram_addr  <= {wr_line_in, fb_acc[1:0], 2'b00};
            end else if (req_read) begin
              state    <= READ;
              beat     <= 2'd0;
              ram_en   <= 1'b1;
              ram_we   <= 4'h0;
              ram_addr <= {req_addr[ADDR_W-1:4], 4'h0};
            end else begin
              // Store with an all-zero mask: nothing to do on the RAM.
              state    <= DONE;
              req_done <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (ram_en && ram_ready) begin
            if (fb_nxt[2]) begin
              beat      <= fb_nxt[1:0];
              ram_we    <= mask_q[4*fb_nxt[1:0] +: 4];
              ram_wdata <= wdata_q[32*fb_nxt[1:0] +: 32];
              ram_addr  <= {wr_line_q, fb_nxt[1:0], 2'b00};
            end else if (rd_q) begin
              state    <= READ;
              beat     <= 2'd0;
              ram_we   <= 4'h0;
              ram_addr <= {rd_line_q, 4'h0};
            end else begin
              state    <= DONE;
              ram_en   <= 1'b0;
              ram_we   <= 4'h0;
              req_done <= 1'b1;
            end
          end
        end

        READ: begin
          if (ram_en && ram_ready) begin
            req_rdata[32*beat +: 32] <= ram_rdata;
            if (beat == 2'd3) begin
              state    <= DONE;
              ram_en   <= 1'b0;
              req_done <= 1'b1;
            end else begin
              beat     <= beat + 2'd1;
              ram_addr <= {rd_line_q, beat + 2'd1, 2'b00};
            end
          end
        end

        DONE: begin
          req_done <= 1'b0;
          req_busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          req_busy <= 1'b0;
          req_done <= 1'b0;
          ram_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl
//   Directed bench for mem_line_ctrl: a table of line requests with expected
//   beat counts, first-beat contents and completion cycle, plus hand-written
//   sequences for reset mid-fill and a request held past req_done.

module tb_mem_line_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req_read, req_write;
  logic [31:0]  req_addr, req_wb_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_mask;
  logic [127:0] req_rdata;
  logic         req_busy, req_done;
  logic         ram_en;
  logic [3:0]   ram_we;
  logic [31:0]  ram_addr, ram_wdata, ram_rdata;
  logic         ram_ready;

  always #5 CLK = ~CLK;

  mem_line_ctrl #(.ADDR_W(32), .LINE_WORDS(4)) dut (
    .CLK(CLK), .RST(RST),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wb_addr(req_wb_addr),
    .req_wdata(req_wdata), .req_mask(req_mask),
    .req_rdata(req_rdata), .req_busy(req_busy), .req_done(req_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // RAM read contents are a fixed function of the word address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // ---------------- RAM model with configurable stall ----------------
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  int          en_cnt = 0;
  logic        snap_v = 1'b0;
  logic [31:0] snap_addr, snap_wd;
  logic [3:0]  snap_we;
  logic [31:0] wlog_addr[$];
  logic [3:0]  wlog_we[$];
  logic [31:0] wlog_wd[$];
  logic [31:0] rlog_addr[$];

  initial begin
    ram_ready = 1'b1;
    ram_rdata = 32'h0;
  end

  always @(negedge CLK) begin
    if (ram_en) begin
      en_cnt++;
      if (snap_v) begin
        chk("stall_addr", {96'h0, ram_addr}, {96'h0, snap_addr});
        chk("stall_we", {124'h0, ram_we}, {124'h0, snap_we});
        chk("stall_wdata", {96'h0, ram_wdata}, {96'h0, snap_wd});
      end
      if (stall_cnt < stall_cfg) begin
        ram_ready = 1'b0;
        ram_rdata = 32'hBAD0_BAD0;
        stall_cnt++;
        snap_v    = 1'b1;
        snap_addr = ram_addr;
        snap_we   = ram_we;
        snap_wd   = ram_wdata;
      end else begin
        ram_ready = 1'b1;
        ram_rdata = pat(ram_addr);
        stall_cnt = 0;
        snap_v    = 1'b0;
        if (ram_we != 4'h0) begin
          wlog_addr.push_back(ram_addr);
          wlog_we.push_back(ram_we);
          wlog_wd.push_back(ram_wdata);
        end else begin
          rlog_addr.push_back(ram_addr);
        end
      end
    end else begin
      // Spurious ready while idle must be ignored.
      ram_ready = 1'b1;
      ram_rdata = 32'hDEAD_BEEF;
      stall_cnt = 0;
      snap_v    = 1'b0;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wb;
    logic [15:0]  mask;
    int           stall;
    int           nwr;
    int           nrd;
    logic [31:0]  wa0;
    logic [3:0]   we0;
    logic [31:0]  wd0;
    logic [31:0]  ra0;
    int           lat;
  } vec_t;

  localparam logic [127:0] W = 128'hD3D3_0003_C2C2_0002_B1B1_0001_A0A0_0000;

  vec_t vt[7];

  task automatic clear_logs();
    wlog_addr.delete(); wlog_we.delete(); wlog_wd.delete(); rlog_addr.delete();
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          lat;
    int          idx;
    logic [127:0] exp_line;
    string       tag;
    tag = $sformatf("v%0d", id);
    clear_logs();
    stall_cfg = v.stall;
    @(negedge CLK);
    chk({tag, "_idle_busy"}, {127'h0, req_busy}, 128'h0);
    req_read    = v.rd;
    req_write   = v.wr;
    req_addr    = v.addr;
    req_wb_addr = v.wb;
    req_wdata   = W;
    req_mask    = v.mask;
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      if (req_done) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 128'(lat), 128'(v.lat));
    chk({tag, "_busy_at_done"}, {127'h0, req_busy}, 128'h1);
    req_read  = 1'b0;
    req_write = 1'b0;
    chk({tag, "_nwr"}, 128'(wlog_addr.size()), 128'(v.nwr));
    chk({tag, "_nrd"}, 128'(rlog_addr.size()), 128'(v.nrd));
    if (wlog_addr.size() > 0) begin
      chk({tag, "_wa0"}, {96'h0, wlog_addr[0]}, {96'h0, v.wa0});
      chk({tag, "_we0"}, {124'h0, wlog_we[0]}, {124'h0, v.we0});
      chk({tag, "_wd0"}, {96'h0, wlog_wd[0]}, {96'h0, v.wd0});
    end
    for (int k = 0; k < wlog_addr.size(); k++) begin
      idx = int'(wlog_addr[k][3:2]);
      chk({tag, "_wline"}, {100'h0, wlog_addr[k][31:4]}, {100'h0, v.wa0[31:4]});
      chk({tag, "_wwe"}, {124'h0, wlog_we[k]}, {124'h0, v.mask[4*idx +: 4]});
      chk({tag, "_wwd"}, {96'h0, wlog_wd[k]}, {96'h0, W[32*idx +: 32]});
    end
    for (int k = 0; k < rlog_addr.size(); k++) begin
      chk({tag, "_raddr"}, {96'h0, rlog_addr[k]}, {96'h0, v.ra0 + 32'(4*k)});
    end
    if (v.nrd == 4) begin
      for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = pat(v.ra0 + 32'(4*k));
      chk({tag, "_rdata"}, req_rdata, exp_line);
    end
    @(negedge CLK);
    chk({tag, "_busy_after"}, {127'h0, req_busy}, 128'h0);
    chk({tag, "_done_after"}, {127'h0, req_done}, 128'h0);
  endtask

  initial begin
    int           lat;
    int           en0;
    int           done_seen;
    logic [127:0] exp_line;

    RST = 1'b1;
    req_read = 1'b0; req_write = 1'b0;
    req_addr = 32'h0; req_wb_addr = 32'h0; req_wdata = '0; req_mask = 16'h0;

    vt[0] = '{1'b1, 1'b0, 32'h0000_2014, 32'h0, 16'h0000, 0, 0, 4, 32'h0, 4'h0, 32'h0, 32'h0000_2010, 5};
    vt[1] = '{1'b1, 1'b1, 32'h0000_5000, 32'h0000_3000, 16'hFFFF, 0, 4, 4, 32'h0000_3000, 4'hF, 32'hA0A0_0000, 32'h0000_5000, 9};
    vt[2] = '{1'b0, 1'b1, 32'h0000_0808, 32'hFFFF_FFF0, 16'h0300, 0, 1, 0, 32'h0000_0808, 4'h3, 32'hC2C2_0002, 32'h0, 2};
    vt[3] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0, 16'h0000, 3, 0, 4, 32'h0, 4'h0, 32'h0, 32'h0000_4000, 17};
    vt[4] = '{1'b0, 1'b1, 32'h0000_1230, 32'h0, 16'h0000, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1};
    vt[5] = '{1'b1, 1'b1, 32'h0000_999C, 32'h0000_7770, 16'hA0C0, 0, 2, 4, 32'h0000_7774, 4'hC, 32'hB1B1_0001, 32'h0000_9990, 7};
    vt[6] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 16'h000F, 2, 1, 0, 32'h0000_0100, 4'hF, 32'hA0A0_0000, 32'h0, 4};

    repeat (3) @(negedge CLK);
    chk("rst_busy", {127'h0, req_busy}, 128'h0);
    chk("rst_done", {127'h0, req_done}, 128'h0);
    chk("rst_rdata", req_rdata, 128'h0);
    chk("rst_ram_en", {127'h0, ram_en}, 128'h0);
    chk("rst_ram_we", {124'h0, ram_we}, 128'h0);
    chk("rst_ram_addr", {96'h0, ram_addr}, 128'h0);
    chk("rst_ram_wdata", {96'h0, ram_wdata}, 128'h0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Reset during READ beat 2 aborts the fill.
    stall_cfg = 0;
    @(negedge CLK);
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h0000_6000;
    repeat (3) @(negedge CLK);
    chk("abort_beat2_addr", {96'h0, ram_addr}, {96'h0, 32'h0000_6008});
    chk("abort_partial", req_rdata[63:0], {pat(32'h0000_6004), pat(32'h0000_6000)});
    RST = 1'b1;
    req_read = 1'b0;
    @(negedge CLK);
    chk("abort_busy", {127'h0, req_busy}, 128'h0);
    chk("abort_ram_en", {127'h0, ram_en}, 128'h0);
    chk("abort_rdata", req_rdata, 128'h0);
    chk("abort_done", {127'h0, req_done}, 128'h0);
    RST = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (req_done) done_seen++;
    end
    chk("abort_no_done", 128'(done_seen), 128'h0);

    // Request still high in the first IDLE cycle becomes a second transfer.
    @(negedge CLK);
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h0000_A000; req_mask = 16'h0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge CLK);
      if (req_done) begin
        lat = c;
        break;
      end
    end
    chk("held_first_lat", 128'(lat), 128'd5);
    req_read = 1'b0; req_write = 1'b1; req_mask = 16'h0000;
    en0 = en_cnt;
    @(negedge CLK);
    chk("held_idle_busy", {127'h0, req_busy}, 128'h0);
    chk("held_idle_done", {127'h0, req_done}, 128'h0);
    @(negedge CLK);
    chk("held_second_done", {127'h0, req_done}, 128'h1);
    chk("held_second_busy", {127'h0, req_busy}, 128'h1);
    req_write = 1'b0;
    @(negedge CLK);
    chk("held_end_busy", {127'h0, req_busy}, 128'h0);
    chk("held_no_ram_en", 128'(en_cnt), 128'(en0));
    for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = pat(32'h0000_A000 + 32'(4*k));
    chk("held_rdata_kept", req_rdata, exp_line);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
